// File: rtl/systolic_skew_buffer_if.sv
// Router-to-array bus for the skew buffer: column vector in, skewed rows out.
interface systolic_skew_buffer_if #(
  parameter int dataSize = 8,
  parameter int nRows    = 9
);
  logic [dataSize-1:0] in_data  [nRows];
  logic                in_valid;
  logic                in_last;
  logic                ctrl_stall;
  logic [dataSize-1:0] out_data [nRows];
  logic [nRows-1:0]    out_valid;
  logic                out_last;
  logic                flag_drained;
  logic                busy;

  modport master (
    output in_data, in_valid, in_last, ctrl_stall,
    input  out_data, out_valid, out_last, flag_drained, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, ctrl_stall,
    output out_data, out_valid, out_last, flag_drained, busy
  );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Delays element r of each column vector by r cycles and tracks the tile-end marker.
// Optional SKEW_OUT_REG_EN adds one output register to every row (latency r+1).
module systolic_skew_buffer #(
  parameter int dataSize = 8,
  parameter int nRows    = 9
) (
  input logic                   clk,
  input logic                   nrst,
  systolic_skew_buffer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   last_tap;
  logic   stage_last;

  logic [dataSize:0] tap   [nRows];
  logic [dataSize:0] stage [nRows];
  logic              last_chain [nRows-1];

  assign accept = bus.in_valid & ~bus.ctrl_stall;

  // Each cell is {valid, data}; non-accept cycles inject an all-zero bubble.
  for (genvar r = 0; r < nRows; r++) begin : g_row
    logic [dataSize:0] row_in;
    assign row_in = accept ? {1'b1, bus.in_data[r]} : '0;

    if (r == 0) begin : g_comb
      assign tap[r] = row_in;
    end else begin : g_chain
      logic [dataSize:0] chain [r];
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int unsigned i = 0; i < r; i++) chain[i] <= '0;
        end else if (!bus.ctrl_stall) begin
          chain[0] <= row_in;
          for (int unsigned i = 1; i < r; i++) chain[i] <= chain[i-1];
        end
      end
      assign tap[r] = chain[r-1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < nRows - 1; i++) last_chain[i] <= 1'b0;
    end else if (!bus.ctrl_stall) begin
      last_chain[0] <= accept & bus.in_last;
      for (int unsigned i = 1; i < nRows - 1; i++) last_chain[i] <= last_chain[i-1];
    end
  end

  assign last_tap = last_chain[nRows-2] & tap[nRows-1][dataSize];

`ifdef SKEW_OUT_REG_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < nRows; i++) stage[i] <= '0;
      stage_last <= 1'b0;
    end else if (!bus.ctrl_stall) begin
      for (int unsigned i = 0; i < nRows; i++) stage[i] <= tap[i];
      stage_last <= last_tap;
    end
  end
`else
  assign stage      = tap;
  assign stage_last = last_tap;
`endif

  always_comb begin
    bus.out_valid = '0;
    for (int unsigned i = 0; i < nRows; i++) begin
      bus.out_valid[i] = stage[i][dataSize];
      bus.out_data[i]  = stage[i][dataSize] ? stage[i][dataSize-1:0] : '0;
    end
  end

  assign bus.out_last     = stage_last;
  assign bus.flag_drained = stage_last & ~bus.ctrl_stall;

  always_comb begin
    state_nxt = state;
    if (!bus.ctrl_stall) begin
      unique case (state)
        S_IDLE:   if (accept) state_nxt = bus.in_last ? S_DRAIN : S_STREAM;
        S_STREAM: if (accept && bus.in_last) state_nxt = S_DRAIN;
        S_DRAIN:  if (bus.flag_drained) state_nxt = accept ? S_STREAM : S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.busy <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Directed plus random checks of the skew buffer against a history-queue reference model.
module tb_systolic_skew_buffer;
  localparam int DW = 8;
  localparam int NR = 9;
`ifdef SKEW_OUT_REG_EN
  localparam int OR = 1;
`else
  localparam int OR = 0;
`endif

  typedef struct packed {
    logic           v;
    logic           l;
    logic [NR*DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  systolic_skew_buffer_if #(.dataSize(DW), .nRows(NR)) bus ();
  systolic_skew_buffer #(.dataSize(DW), .nRows(NR)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // stimulus for the next cycle
  logic          vi, vl, st;
  logic [DW-1:0] vd [NR];

  // reference model: newest accepted/bubble entry at the front
  ent_t hist[$];
  int   mode;          // 0 idle, 1 streaming, 2 draining
  int   cyc, flags, fcyc, lcyc;

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    ent_t cur, e;
    logic [NR*DW-1:0] ed, od;
    logic [NR-1:0]    ev;
    logic             el, ef, acc;
    int               lat;
    bus.in_valid   = vi;
    bus.in_last    = vl;
    bus.ctrl_stall = st;
    for (int r = 0; r < NR; r++) bus.in_data[r] = vd[r];
    @(negedge clk);
    acc = vi & ~st;
    cur.v = acc;
    cur.l = acc & vl;
    cur.d = '0;
    for (int r = 0; r < NR; r++) if (acc) cur.d[r*DW +: DW] = vd[r];
    ed = '0; ev = '0; el = 1'b0;
    for (int r = 0; r < NR; r++) begin
      lat = r + OR;
      if (lat == 0) e = cur;
      else if (hist.size() >= lat) e = hist[lat-1];
      else e = '0;
      ev[r] = e.v;
      if (e.v) ed[r*DW +: DW] = e.d[r*DW +: DW];
      if (r == NR - 1) el = e.v & e.l;
    end
    ef = el & ~st;
    for (int r = 0; r < NR; r++) od[r*DW +: DW] = bus.out_data[r];
    check("out_valid", {{(NR*DW-NR){1'b0}}, bus.out_valid}, {{(NR*DW-NR){1'b0}}, ev});
    check("out_data", od, ed);
    check("out_last", {{(NR*DW-1){1'b0}}, bus.out_last}, {{(NR*DW-1){1'b0}}, el});
    check("flag_drained", {{(NR*DW-1){1'b0}}, bus.flag_drained}, {{(NR*DW-1){1'b0}}, ef});
    check("busy", {{(NR*DW-1){1'b0}}, bus.busy}, {{(NR*DW-1){1'b0}}, logic'(mode != 0)});
    if (bus.flag_drained === 1'b1) begin
      flags++;
      if (fcyc < 0) fcyc = cyc;
      lcyc = cyc;
    end
    if (!st) begin
      hist.push_front(cur);
      while (hist.size() > NR + 1) void'(hist.pop_back());
      case (mode)
        0: if (acc) mode = vl ? 2 : 1;
        1: if (acc && vl) mode = 2;
        default: if (ef) mode = acc ? 1 : 0;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int v, input int l, input int s, input int base);
    vi = 1'(v); vl = 1'(l); st = 1'(s);
    for (int r = 0; r < NR; r++) vd[r] = DW'(base + r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_vec(0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic scen_start();
    cyc = 0; flags = 0; fcyc = -1; lcyc = -1;
  endtask

  initial begin
    mode = 0;
    set_vec(0, 0, 0, 0);
    bus.in_valid = 0; bus.in_last = 0; bus.ctrl_stall = 0;
    for (int r = 0; r < NR; r++) bus.in_data[r] = '0;
    @(negedge clk);
    check("rst_valid", {{(NR*DW-NR){1'b0}}, bus.out_valid}, '0);
    check("rst_busy", {{(NR*DW-1){1'b0}}, bus.busy}, '0);
    check("rst_flag", {{(NR*DW-1){1'b0}}, bus.flag_drained}, '0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // single vector, last set
    scen_start();
    set_vec(1, 1, 0, 1); tick();
    idle(NR + 3);
    check("single_fcyc", NR*DW'(fcyc), NR*DW'(NR - 1 + OR));
    check("single_flags", NR*DW'(flags), NR*DW'(1));

    // three vectors 10k+r, last on k=2
    scen_start();
    for (int k = 0; k < 3; k++) begin set_vec(1, int'(k == 2), 0, 10*k); tick(); end
    idle(NR + 3);
    check("three_fcyc", NR*DW'(fcyc), NR*DW'(NR + 1 + OR));
    check("three_flags", NR*DW'(flags), NR*DW'(1));

    // same with a 2-cycle stall at cycle 4
    scen_start();
    for (int k = 0; k < 3; k++) begin set_vec(1, int'(k == 2), 0, 10*k); tick(); end
    idle(1);
    set_vec(1, 1, 1, 77); tick(); tick();
    idle(NR + 3);
    check("stall_fcyc", NR*DW'(fcyc), NR*DW'(NR + 3 + OR));
    check("stall_flags", NR*DW'(flags), NR*DW'(1));

    // back-to-back tiles: next first vector on the drain cycle
    scen_start();
    set_vec(1, 0, 0, 20); tick();
    set_vec(1, 1, 0, 30); tick();
    idle(NR + OR - 2);
    set_vec(1, 0, 0, 40); tick();
    set_vec(1, 1, 0, 50); tick();
    idle(NR + 3);
    check("b2b_fcyc", NR*DW'(fcyc), NR*DW'(NR + OR));
    check("b2b_lcyc", NR*DW'(lcyc), NR*DW'(2*NR + OR));
    check("b2b_flags", NR*DW'(flags), NR*DW'(2));

    // reset mid-stream discards everything
    scen_start();
    for (int k = 0; k < 4; k++) begin set_vec(1, int'(k == 3), 0, 60 + k); tick(); end
    set_vec(0, 0, 0, 0);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    nrst = 1'b0;
    #1;
    check("mrst_valid", {{(NR*DW-NR){1'b0}}, bus.out_valid}, '0);
    check("mrst_busy", {{(NR*DW-1){1'b0}}, bus.busy}, '0);
    for (int r = 0; r < NR; r++) check("mrst_data", NR*DW'(bus.out_data[r]), '0);
    hist.delete();
    mode = 0;
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(NR + 3);
    check("mrst_flags", NR*DW'(flags), '0);

    // random traffic
    scen_start();
    for (int i = 0; i < 400; i++) begin
      set_vec(int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 9) < 2),
              int'($urandom_range(0, 9) < 2), int'($urandom_range(0, 255)));
      for (int r = 0; r < NR; r++) vd[r] = DW'($urandom);
      tick();
    end
    idle(NR + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_skew_buffer.md
Name: systolic_skew_buffer

Overview:
- Sits directly downstream of the Toeplitz buffer router and directly upstream of the systolic array's row inputs.
- Each cycle it takes one column vector of nRows elements (the router's rd_data) and delays element r by r cycles, producing the diagonal wavefront the array needs.
- Tracks a tile-end marker through the skew and reports when the last element has left the deepest row.

Parameters:
- dataSize, 8, element width in bits.
- nRows, 9, number of elements per vector; equals nPEy of the array and the router's nElementsOut. Must be >= 2.

Ports:
- clk  input  1  clock.
- nrst  input  1  asynchronous active-low reset.
- in_data  input  dataSize x nRows (unpacked array)  column vector from the router.
- in_valid  input  1  in_data is valid this cycle; high while the router computes.
- in_last  input  1  marks the final vector of a tile; driven from the router's flag_done; qualified by in_valid.
- ctrl_stall  input  1  freezes the whole block for this cycle.
- out_data  output  dataSize x nRows (unpacked array)  skewed elements to array rows.
- out_valid  output  nRows  per-row valid.
- out_last  output  1  row nRows-1 is presenting the element that entered with in_last.
- flag_drained  output  1  one-cycle pulse when the tile has fully left the skew.
- busy  output  1  high when state is not S_IDLE.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on nrst. All state clears on reset.
- Reset values: all delay registers, valid bits and the last bit = 0; state = S_IDLE; busy = 0; flag_drained = 0.
- A vector is accepted when in_valid=1 and ctrl_stall=0. With ctrl_stall=1, in_data, in_valid and in_last are ignored; upstream must hold them.
- Row r uses a chain of r registers, each dataSize+1 bits (data plus valid).
  - Row 0 is combinational: out_data[0] = in_data[0] and out_valid[0] = in_valid & !ctrl_stall.
  - Row r presents the element accepted r advancing cycles earlier.
- Registers shift only on cycles with ctrl_stall=0. On non-accept cycles, a bubble (valid=0, data=0) shifts in.
- out_data[r] = 0 whenever out_valid[r] = 0. No stale data reaches the array.
- While stalled, all registered rows hold their values. Row 0 shows valid=0.
- A last bit travels alongside row nRows-1's chain.
  - out_last = that chain's output last bit & its valid bit.
  - flag_drained = out_last & !ctrl_stall. A stalled drain delays the pulse; it is never lost or duplicated.
- The datapath is independent of the FSM; the FSM only drives busy.
- FSM, evaluated on non-stall cycles:
  - S_IDLE -> S_STREAM on accept with in_last=0.
  - S_IDLE -> S_DRAIN on accept with in_last=1.
  - S_STREAM -> S_DRAIN on accept with in_last=1.
  - S_DRAIN -> S_IDLE on flag_drained with no accept that cycle.
  - S_DRAIN -> S_STREAM on flag_drained with a simultaneous accept. This supports back-to-back tiles.
  - S_DRAIN stays in S_DRAIN otherwise, including when a new accept arrives before drain completes.
- Drain latency: flag_drained fires nRows-1 advancing cycles after the in_last vector is accepted.
- Reset mid-tile discards all in-flight data with no flag_drained.
- Storage: nRows(nRows-1)/2 element registers; 36 for the default.

Optional Feature:
- Macro: SKEW_OUT_REG_EN.
- Defined: every row gets one extra output register, including row 0, so all outputs are registered.
  - Row r latency becomes r+1.
  - flag_drained fires nRows cycles after the last accept.
  - Stall freezes the output register as well.
- Undefined: behaviour as above; row 0 is combinational.

Test Plan:
- Reset with nrst=0 mid-stream, then release -> all out_valid=0, out_data=0, busy=0, state S_IDLE; no flag_drained ever follows.
- Single vector in_data[r]=r+1, in_valid=1, in_last=1, default nRows=9 -> out_valid[r]=1 with value r+1 exactly r cycles later; flag_drained on cycle 8 only; busy falls the cycle after.
- 3 consecutive vectors with values 10k+r for k=0..2, last on k=2 -> row r emits 10k+r at cycle k+r; only one flag_drained, at cycle 10.
- ctrl_stall=1 for 2 cycles at cycle 4 of the previous test -> rows 1..8 hold their values; row 0 valid=0 during the stall; all later outputs shifted by 2; flag_drained at cycle 12.
- Back-to-back tiles: next tile's first vector accepted on the same cycle as flag_drained -> state goes to S_STREAM, busy stays 1, second flag_drained 8 cycles after the second last.
- With SKEW_OUT_REG_EN defined, rerun the single-vector test -> row r value appears at cycle r+1; flag_drained at cycle 9.
